mips_mc_core: RTL
=================

// Module: mips_mc_core
// PURPOSE
//  Parametrised multicycle MIPS core; next generation of the single-cycle top. FSM sequences each
//  instruction over 3-5 cycles and shares one ALU and one unified instruction/data memory port.
//  The memory port uses a req/ready handshake, so the core tolerates variable-latency memory.
//  Sits between the system memory fabric and the debug/halt logic.
// PARAMETERS
//  DATA_WIDTH  32  datapath, register and memory word width (>=32)
//  ADDR_WIDTH  32  word-address width of PC and mem_addr
//  PC_RESET    0   PC value loaded on reset
//  HALT_OPCODE 6'h3F  opcode that stops the core
// PORTS
//  clk        in   1           clock, rising edge
//  rst        in   1           asynchronous, active-high reset
//  mem_req    out  1           memory request valid
//  mem_we     out  1           1 = write (sw), 0 = read
//  mem_addr   out  ADDR_WIDTH  word address
//  mem_wdata  out  DATA_WIDTH  store data
//  mem_rdata  in   DATA_WIDTH  read data, valid in the cycle mem_ready=1
//  mem_ready  in   1           request accepted and completed this cycle
//  halted     out  1           core stopped (HALT_OPCODE or illegal instruction)
//  illegal    out  1           halt caused by undecodable opcode/funct
//  pc_out     out  ADDR_WIDTH  current PC, for debug
// BEHAVIOUR
//  Reset: one clock; rst is asynchronous and active-high. While rst=1:
//   - state=IDLE, PC=PC_RESET, IR=0
//   - mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, halted=0, illegal=0
//   - register file contents are not reset.
//  FSM: IDLE->FETCH (1 cycle after rst release).
//   FETCH: mem_req=1, mem_we=0, mem_addr=PC; hold until mem_ready, then IR<=mem_rdata, PC<=PC+1, ->DECODE.
//   DECODE: read rs/rt into A/B; sign-extend imm.
//    HALT_OPCODE -> HALT. Unknown opcode or funct -> HALT with illegal=1. Otherwise ->EXEC.
//   EXEC by instruction class:
//    R-type/addi: ALUOut<=A op (B|se_imm), ->WB
//    lw/sw: ALUOut<=A+se_imm, ->MEM
//    beq: if A==B then PC<=PC+se_imm (PC already +1); ->FETCH
//    j: PC<={PC[ADDR_WIDTH-1:26],target}; ->FETCH
//   MEM: mem_req=1, mem_addr=ALUOut[ADDR_WIDTH-1:0]; mem_we=1 and mem_wdata=B for sw.
//    Wait for mem_ready. sw ->FETCH; lw: MDR<=mem_rdata, ->WB.
//   WB: write rd (R-type), rt (addi), or rt<=MDR (lw) ->FETCH.
//   HALT: absorbing; halted=1, mem_req=0. Only rst exits.
//  Handshake: while mem_req=1 and mem_ready=0, mem_req/we/addr/wdata stay stable.
//   mem_ready while mem_req=0 is ignored.
//  Latency with zero-wait memory:
//   beq/j: 3 cycles; R-type/addi/sw: 4; lw: 5. Each wait cycle adds 1.
//  Arithmetic: modulo 2^DATA_WIDTH, no overflow trap. slt is signed.
//   sll/srl shift rt by shamt. PC wraps modulo 2^ADDR_WIDTH.
//  Register $0 always reads 0; writes to $0 are dropped. Regfile is written only in WB.
//  Same-register read-after-write needs no forwarding, since instructions never overlap.
//  rst asserted mid-access drops mem_req immediately (async). No partial write is retried.
//  Supported set: add sub and or slt sll srl addi lw sw beq j, plus HALT_OPCODE.
// STRUCTURE
//  Package MIPS_MC_Definitions:
//   - mc_state_t enum {IDLE,FETCH,DECODE,EXEC,MEM,WB,HALT}
//   - instruction-class enum; opcode/funct constants; HALT_OPCODE default
//   - reuses mips_instruction_t and alu_sel_t.
//  Sub-module mips_mc_control_fsm:
//   - inputs: state, opcode, funct, mem_ready, zero
//   - outputs: next state, register enables (IR, PC, A/B, ALUOut, MDR), mux selects, alu_sel
//  Datapath in mips_mc_core reuses MIPS_Register_File, MIPS_ALU and Sign_Extension_Unit.
// TESTING
//  1. Reset/fetch: rst 3 cycles, release, mem_ready tied 1
//     -> mem_req rises 1 cycle after release, mem_addr=0; pc_out=1 after fetch.
//  2. ALU program with mem_ready=1:
//     addi $1,$0,5; addi $2,$0,-3; add $3,$1,$2; slt $4,$2,$1; sll $5,$1,2
//     -> $3=2, $4=1, $5=20; each instruction takes 4 cycles.
//  3. Memory wait states: sw $1,8($0) then lw $6,8($0) with mem_ready low for 3 cycles
//     -> mem_addr=8, we=1, wdata=5 held stable; $6=5; lw takes 8 cycles.
//  4. Control flow: beq $1,$1,-1 at PC=10 -> next fetch at addr 10.
//     beq not taken -> 11. j 0x40 -> fetch at 0x40.
//  5. Halt/illegal: HALT_OPCODE -> halted=1, mem_req=0 forever.
//     Undefined opcode 6'h3A -> halted=1, illegal=1. rst clears both.
//  6. Write to $0 and reset mid-MEM: addi $0,$0,7 -> $0 reads 0.
//     rst during a stalled sw -> mem_req=0 in the same cycle, PC=PC_RESET.

Source files
------------

// File: rtl/mips_mc_core_pkg.sv
// Shared types and encodings for the multicycle MIPS core: FSM states,
// instruction classes, ALU operations and opcode/funct constants.
package mips_mc_core_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DECODE,
    EXEC,
    MEM,
    WB,
    HALT
  } mc_state_t;

  typedef enum logic [2:0] {
    CLS_RTYPE,
    CLS_ADDI,
    CLS_LW,
    CLS_SW,
    CLS_BEQ,
    CLS_J,
    CLS_HALT,
    CLS_ILLEGAL
  } instr_class_t;

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_SLT,
    ALU_SLL,
    ALU_SRL
  } alu_sel_t;

  typedef enum logic [1:0] {
    PC_SRC_INC,
    PC_SRC_BRANCH,
    PC_SRC_JUMP
  } pc_src_t;

  typedef struct packed {
    logic [5:0] opcode;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic [4:0] shamt;
    logic [5:0] funct;
  } mips_instruction_t;

  localparam logic [5:0] OP_RTYPE        = 6'h00;
  localparam logic [5:0] OP_J            = 6'h02;
  localparam logic [5:0] OP_BEQ          = 6'h04;
  localparam logic [5:0] OP_ADDI         = 6'h08;
  localparam logic [5:0] OP_LW           = 6'h23;
  localparam logic [5:0] OP_SW           = 6'h2B;
  localparam logic [5:0] OP_HALT_DEFAULT = 6'h3F;

  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  // The halt opcode is checked first so it may alias any other encoding.
  function automatic instr_class_t classify(input logic [5:0] opcode,
                                            input logic [5:0] funct,
                                            input logic [5:0] halt_op);
    instr_class_t cls;
    cls = CLS_ILLEGAL;
    if (opcode == halt_op) begin
      cls = CLS_HALT;
    end else begin
      case (opcode)
        OP_RTYPE: begin
          case (funct)
            FN_SLL, FN_SRL, FN_ADD, FN_SUB,
            FN_AND, FN_OR, FN_SLT: cls = CLS_RTYPE;
            default:               cls = CLS_ILLEGAL;
          endcase
        end
        OP_ADDI: cls = CLS_ADDI;
        OP_LW:   cls = CLS_LW;
        OP_SW:   cls = CLS_SW;
        OP_BEQ:  cls = CLS_BEQ;
        OP_J:    cls = CLS_J;
        default: cls = CLS_ILLEGAL;
      endcase
    end
    return cls;
  endfunction

  function automatic alu_sel_t funct_to_alu(input logic [5:0] funct);
    alu_sel_t sel;
    case (funct)
      FN_SUB:  sel = ALU_SUB;
      FN_AND:  sel = ALU_AND;
      FN_OR:   sel = ALU_OR;
      FN_SLT:  sel = ALU_SLT;
      FN_SLL:  sel = ALU_SLL;
      FN_SRL:  sel = ALU_SRL;
      default: sel = ALU_ADD;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/mips_mc_core_ctrl.sv
// Control decode for the multicycle core: next state, datapath register
// enables and mux selects from the current state and the latched instruction.
module mips_mc_core_ctrl
  import mips_mc_core_pkg::*;
#(
  parameter logic [5:0] HALT_OPCODE = OP_HALT_DEFAULT
) (
  input  mc_state_t  state_i,
  input  logic [5:0] opcode_i,
  input  logic [5:0] funct_i,
  input  logic       mem_ready_i,
  input  logic       zero_i,
  output mc_state_t  state_d_o,
  output logic       ir_we_o,
  output logic       pc_we_o,
  output logic       ab_we_o,
  output logic       aluout_we_o,
  output logic       mdr_we_o,
  output logic       rf_we_o,
  output pc_src_t    pc_src_o,
  output logic       alu_b_imm_o,
  output logic       rf_dst_rd_o,
  output logic       rf_from_mdr_o,
  output logic       is_store_o,
  output logic       illegal_set_o,
  output alu_sel_t   alu_sel_o
);

  instr_class_t cls;

  assign cls = classify(opcode_i, funct_i, HALT_OPCODE);

  always_comb begin
    state_d_o     = state_i;
    ir_we_o       = 1'b0;
    pc_we_o       = 1'b0;
    ab_we_o       = 1'b0;
    aluout_we_o   = 1'b0;
    mdr_we_o      = 1'b0;
    rf_we_o       = 1'b0;
    pc_src_o      = PC_SRC_INC;
    illegal_set_o = 1'b0;
    alu_b_imm_o   = (cls == CLS_ADDI) || (cls == CLS_LW) || (cls == CLS_SW);
    rf_dst_rd_o   = (cls == CLS_RTYPE);
    rf_from_mdr_o = (cls == CLS_LW);
    is_store_o    = (cls == CLS_SW);

    // beq compares through the shared ALU: A - B == 0
    case (cls)
      CLS_RTYPE: alu_sel_o = funct_to_alu(funct_i);
      CLS_BEQ:   alu_sel_o = ALU_SUB;
      default:   alu_sel_o = ALU_ADD;
    endcase

    case (state_i)
      IDLE: state_d_o = FETCH;
      FETCH: begin
        if (mem_ready_i) begin
          ir_we_o   = 1'b1;
          pc_we_o   = 1'b1;
          state_d_o = DECODE;
        end
      end
      DECODE: begin
        ab_we_o = 1'b1;
        if (cls == CLS_HALT) begin
          state_d_o = HALT;
        end else if (cls == CLS_ILLEGAL) begin
          illegal_set_o = 1'b1;
          state_d_o     = HALT;
        end else begin
          state_d_o = EXEC;
        end
      end
      EXEC: begin
        case (cls)
          CLS_RTYPE, CLS_ADDI: begin
            aluout_we_o = 1'b1;
            state_d_o   = WB;
          end
          CLS_LW, CLS_SW: begin
            aluout_we_o = 1'b1;
            state_d_o   = MEM;
          end
          CLS_BEQ: begin
            pc_we_o   = zero_i;
            pc_src_o  = PC_SRC_BRANCH;
            state_d_o = FETCH;
          end
          CLS_J: begin
            pc_we_o   = 1'b1;
            pc_src_o  = PC_SRC_JUMP;
            state_d_o = FETCH;
          end
          default: state_d_o = HALT;
        endcase
      end
      MEM: begin
        if (mem_ready_i) begin
          if (cls == CLS_LW) begin
            mdr_we_o  = 1'b1;
            state_d_o = WB;
          end else begin
            state_d_o = FETCH;
          end
        end
      end
      WB: begin
        rf_we_o   = 1'b1;
        state_d_o = FETCH;
      end
      HALT:    state_d_o = HALT;
      default: state_d_o = IDLE;
    endcase
  end

endmodule

// File: rtl/mips_mc_core.sv
// Multicycle MIPS core: one shared ALU, unified req/ready memory port,
// state and memory-port outputs registered in a single sequential block.
module mips_mc_core
  import mips_mc_core_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH  = 32,
  parameter int unsigned           ADDR_WIDTH  = 32,
  parameter logic [ADDR_WIDTH-1:0] PC_RESET    = '0,
  parameter logic [5:0]            HALT_OPCODE = OP_HALT_DEFAULT
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  input  logic                  mem_ready_i,
  output logic                  halted_o,
  output logic                  illegal_o,
  output logic [ADDR_WIDTH-1:0] pc_out_o
);

  mc_state_t               state_q, state_d;
  logic [ADDR_WIDTH-1:0]   pc_q, pc_d;
  logic [31:0]             ir_q;
  logic [DATA_WIDTH-1:0]   a_q, b_q, aluout_q, mdr_q;
  logic                    mem_req_q, mem_req_d;
  logic                    mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0]   mem_wdata_q, mem_wdata_d;
  logic                    halted_q, illegal_q;
  logic [DATA_WIDTH-1:0]   rf_q [32];

  mips_instruction_t       ins;
  logic                    ir_we, pc_we, ab_we, aluout_we, mdr_we, rf_we;
  pc_src_t                 pc_src;
  logic                    alu_b_imm, rf_dst_rd, rf_from_mdr, is_store, illegal_set;
  alu_sel_t                alu_sel;
  logic                    zero;
  logic [DATA_WIDTH-1:0]   se_imm, alu_b, alu_res;
  logic [ADDR_WIDTH-1:0]   se_imm_a;
  logic [DATA_WIDTH-1:0]   rf_rdata_a, rf_rdata_b, rf_wdata;
  logic [4:0]              rf_waddr;

  assign ins      = ir_q;
  assign se_imm   = {{(DATA_WIDTH-16){ir_q[15]}}, ir_q[15:0]};
  assign se_imm_a = {{(ADDR_WIDTH-16){ir_q[15]}}, ir_q[15:0]};

  mips_mc_core_ctrl #(
    .HALT_OPCODE (HALT_OPCODE)
  ) u_ctrl (
    .state_i       (state_q),
    .opcode_i      (ins.opcode),
    .funct_i       (ins.funct),
    .mem_ready_i   (mem_ready_i & mem_req_q),
    .zero_i        (zero),
    .state_d_o     (state_d),
    .ir_we_o       (ir_we),
    .pc_we_o       (pc_we),
    .ab_we_o       (ab_we),
    .aluout_we_o   (aluout_we),
    .mdr_we_o      (mdr_we),
    .rf_we_o       (rf_we),
    .pc_src_o      (pc_src),
    .alu_b_imm_o   (alu_b_imm),
    .rf_dst_rd_o   (rf_dst_rd),
    .rf_from_mdr_o (rf_from_mdr),
    .is_store_o    (is_store),
    .illegal_set_o (illegal_set),
    .alu_sel_o     (alu_sel)
  );

  // $0 is hardwired through the read mux; its storage slot is never written.
  assign rf_rdata_a = (ins.rs == 5'd0) ? '0 : rf_q[ins.rs];
  assign rf_rdata_b = (ins.rt == 5'd0) ? '0 : rf_q[ins.rt];
  assign rf_waddr   = rf_dst_rd ? ins.rd : ins.rt;
  assign rf_wdata   = rf_from_mdr ? mdr_q : aluout_q;

  always_ff @(posedge clk_i) begin
    if (rf_we && (rf_waddr != 5'd0)) begin
      rf_q[rf_waddr] <= rf_wdata;
    end
  end

  assign alu_b = alu_b_imm ? se_imm : b_q;

  always_comb begin
    alu_res = '0;
    case (alu_sel)
      ALU_ADD: alu_res = a_q + alu_b;
      ALU_SUB: alu_res = a_q - alu_b;
      ALU_AND: alu_res = a_q & alu_b;
      ALU_OR:  alu_res = a_q | alu_b;
      ALU_SLT: alu_res = {{(DATA_WIDTH-1){1'b0}}, ($signed(a_q) < $signed(alu_b))};
      ALU_SLL: alu_res = alu_b << ins.shamt;
      ALU_SRL: alu_res = alu_b >> ins.shamt;
      default: alu_res = '0;
    endcase
  end

  assign zero = (alu_res == '0);

  always_comb begin
    pc_d = pc_q;
    if (pc_we) begin
      case (pc_src)
        PC_SRC_INC:    pc_d = pc_q + ADDR_WIDTH'(1);
        PC_SRC_BRANCH: pc_d = pc_q + se_imm_a;
        PC_SRC_JUMP:   pc_d = {pc_q[ADDR_WIDTH-1:26], ir_q[25:0]};
        default:       pc_d = pc_q;
      endcase
    end
  end

  // Port values are computed for the state being entered so they are
  // registered and stay frozen while a request waits for mem_ready.
  always_comb begin
    mem_req_d   = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = '0;
    mem_wdata_d = '0;
    if (state_d == FETCH) begin
      mem_req_d  = 1'b1;
      mem_addr_d = pc_d;
    end else if (state_d == MEM) begin
      if (state_q == EXEC) begin
        mem_req_d   = 1'b1;
        mem_we_d    = is_store;
        mem_addr_d  = alu_res[ADDR_WIDTH-1:0];
        mem_wdata_d = is_store ? b_q : '0;
      end else begin
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      pc_q        <= PC_RESET;
      ir_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      aluout_q    <= '0;
      mdr_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      halted_q    <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      halted_q    <= (state_d == HALT);
      illegal_q   <= illegal_q | illegal_set;
      if (ir_we) begin
        ir_q <= mem_rdata_i[31:0];
      end
      if (ab_we) begin
        a_q <= rf_rdata_a;
        b_q <= rf_rdata_b;
      end
      if (aluout_we) begin
        aluout_q <= alu_res;
      end
      if (mdr_we) begin
        mdr_q <= mem_rdata_i;
      end
    end
  end

  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign halted_o    = halted_q;
  assign illegal_o   = illegal_q;
  assign pc_out_o    = pc_q;

endmodule
